// File: rtl/pam4_sym_src_pkg.sv
// Shared PAM4 transmit defines: symbol width, level constants, PRBS15 step and bit-pair mapping.
// Mapping follows PAM4_GRAY_MAP_EN when defined, natural binary otherwise.
package pam4_sym_src_pkg;

    localparam int unsigned SYM_W = 18;

    typedef logic signed [SYM_W-1:0] sym_t;
    typedef logic [14:0]             lfsr_t;

    localparam sym_t SYMBOL_N2 = sym_t'(-98304);
    localparam sym_t SYMBOL_N1 = sym_t'(-32768);
    localparam sym_t SYMBOL_P1 = sym_t'(32768);
    localparam sym_t SYMBOL_P2 = sym_t'(98304);

    function automatic lfsr_t lfsr_step(input lfsr_t s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic sym_t pam4_level(input logic [1:0] bits);
        sym_t lvl;
        lvl = SYMBOL_N2;
        case (bits)
            2'b00: lvl = SYMBOL_N2;
            2'b01: lvl = SYMBOL_N1;
`ifdef PAM4_GRAY_MAP_EN
            2'b11: lvl = SYMBOL_P1;
            2'b10: lvl = SYMBOL_P2;
`else
            2'b10: lvl = SYMBOL_P1;
            2'b11: lvl = SYMBOL_P2;
`endif
            default: lvl = SYMBOL_N2;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/pam4_sym_src_lfsr.sv
// PRBS15 Fibonacci generator advancing two bits per enabled step; seed load wins over step.
module prbs15_lfsr
    import pam4_sym_src_pkg::*;
#(
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    input  logic        seed_load,
    output logic [14:0] state,
    output logic        bit_out
);

    lfsr_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (seed_load)
            state_d = SEED;
        else if (step_en)
            state_d = lfsr_step(lfsr_step(state_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state   = state_q;
    assign bit_out = state_q[14] ^ state_q[13];

endmodule

// File: rtl/pam4_sym_src.sv
// PAM4 PRBS symbol source with sample/symbol strobes and frame marker.
// Level mapping selected by macro PAM4_GRAY_MAP_EN (Gray when defined, natural binary otherwise).
module pam4_sym_src
    import pam4_sym_src_pkg::*;
#(
    parameter int unsigned CLK_PER_SAM = 4,
    parameter int unsigned FRAME_LEN   = 1024,
    parameter logic [14:0] LFSR_SEED   = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        sam_clk_en,
    output logic        sym_clk_en,
    output logic [1:0]  sym_bits,
    output logic [17:0] sym_out,
    output logic        frame_start
);

    localparam logic [3:0]  CLK_LAST   = 4'(CLK_PER_SAM - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_LEN - 1);

    logic [3:0]  clk_cnt_q, clk_cnt_d;
    logic [1:0]  sam_cnt_q, sam_cnt_d;
    logic        sam_en_q, sam_en_d;
    logic        sym_en_q, sym_en_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]  bits_q, bits_d;
    sym_t        out_q, out_d;
    logic        fs_q, fs_d;

    logic        sam_tick;
    logic        lfsr_step_en;
    logic        lfsr_load;
    logic [14:0] lfsr_state;
    logic        lfsr_bit;

    prbs15_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .step_en   (lfsr_step_en),
        .seed_load (lfsr_load),
        .state     (lfsr_state),
        .bit_out   (lfsr_bit)
    );

    // Strobes are registered: the tick seen in cycle k-1 raises the strobe after edge k.
    always_comb begin
        sam_tick  = (clk_cnt_q == CLK_LAST);
        clk_cnt_d = sam_tick ? '0 : clk_cnt_q + 4'd1;
        sam_cnt_d = sam_tick ? sam_cnt_q + 2'd1 : sam_cnt_q;
        sam_en_d  = sam_tick;
        sym_en_d  = sam_tick && (sam_cnt_q == 2'd3);

        lfsr_load    = sym_en_q && (lfsr_state == '0);
        lfsr_step_en = sym_en_q && run;

        frame_cnt_d = frame_cnt_q;
        bits_d      = bits_q;
        out_d       = out_q;
        fs_d        = fs_q;
        if (sym_en_q) begin
            if (run) begin
                // Second bit is the feedback of the once-stepped state.
                bits_d      = {lfsr_bit, lfsr_state[13] ^ lfsr_state[12]};
                out_d       = pam4_level(bits_d);
                fs_d        = (frame_cnt_q == '0);
                frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 16'd1;
            end else begin
                bits_d      = '0;
                out_d       = '0;
                fs_d        = 1'b0;
                frame_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt_q   <= '0;
            sam_cnt_q   <= '0;
            sam_en_q    <= 1'b0;
            sym_en_q    <= 1'b0;
            frame_cnt_q <= '0;
            bits_q      <= '0;
            out_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            clk_cnt_q   <= clk_cnt_d;
            sam_cnt_q   <= sam_cnt_d;
            sam_en_q    <= sam_en_d;
            sym_en_q    <= sym_en_d;
            frame_cnt_q <= frame_cnt_d;
            bits_q      <= bits_d;
            out_q       <= out_d;
            fs_q        <= fs_d;
        end
    end

    assign sam_clk_en  = sam_en_q;
    assign sym_clk_en  = sym_en_q;
    assign sym_bits    = bits_q;
    assign sym_out     = out_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_pam4_sym_src.sv
// Self-checking bench for pam4_sym_src against a PRBS/frame reference model.
module tb_pam4_sym_src;

    localparam int CPS  = 4;
    localparam int FL   = 4;
    localparam int SEED = 32'h7FFF;
`ifdef PAM4_GRAY_MAP_EN
    localparam int LEVEL_10 = 98304;
`else
    localparam int LEVEL_10 = 32768;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        sam_clk_en, sym_clk_en, frame_start;
    logic [1:0]  sym_bits;
    logic [17:0] sym_out;

    int total = 0;
    int bad = 0;

    int         m_lfsr, m_fcnt;
    logic [1:0] e_bits;
    int         e_out;
    logic       e_fs;
    bit         have_prev;

    pam4_sym_src #(
        .CLK_PER_SAM (CPS),
        .FRAME_LEN   (FL),
        .LFSR_SEED   (15'h7FFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .sam_clk_en  (sam_clk_en),
        .sym_clk_en  (sym_clk_en),
        .sym_bits    (sym_bits),
        .sym_out     (sym_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int level_of(input logic [1:0] b);
        int idx;
`ifdef PAM4_GRAY_MAP_EN
        idx = int'(b ^ (b >> 1));
`else
        idx = int'(b);
`endif
        return -98304 + 65536 * idx;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_fcnt = 0; e_bits = 2'b00; e_out = 0; e_fs = 1'b0; have_prev = 0;
    endtask

    task automatic prbs_bit(output int b);
        b = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
        m_lfsr = ((m_lfsr << 1) | b) & 32'h7FFF;
    endtask

    task automatic model_symbol(input bit r);
        int b1, b2;
        b1 = 0; b2 = 0;
        if (m_lfsr == 0) m_lfsr = SEED;
        else if (r) begin prbs_bit(b1); prbs_bit(b2); end
        if (r) begin
            e_bits = {b1[0], b2[0]};
            e_out  = level_of(e_bits);
            e_fs   = (m_fcnt == 0);
            m_fcnt = (m_fcnt + 1) % FL;
        end else begin
            e_bits = 2'b00; e_out = 0; e_fs = 1'b0; m_fcnt = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_symbol(input bit r);
        int n;
        run = r;
        n = 0;
        while (sym_clk_en !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (sym_clk_en !== 1'b1) begin
            bad++;
            $display("FAIL sym_strobe_timeout got=%b want=1", sym_clk_en);
            return;
        end
        if (have_prev) begin
            total++;
            if (sym_bits !== e_bits || int'($signed(sym_out)) != e_out || frame_start !== e_fs) begin
                bad++;
                $display("FAIL hold_at_strobe got=%b/%0d/%b want=%b/%0d/%b",
                         sym_bits, $signed(sym_out), frame_start, e_bits, e_out, e_fs);
            end
        end
        model_symbol(r);
        @(posedge clk); #1;
        total++;
        if (sym_bits !== e_bits) begin
            bad++; $display("FAIL sym_bits got=%b want=%b", sym_bits, e_bits);
        end
        total++;
        if (int'($signed(sym_out)) != e_out) begin
            bad++; $display("FAIL sym_out got=%0d want=%0d", $signed(sym_out), e_out);
        end
        total++;
        if (frame_start !== e_fs) begin
            bad++; $display("FAIL frame_start got=%b want=%b", frame_start, e_fs);
        end
        if (r && sym_bits == 2'b10) begin
            total++;
            if (int'($signed(sym_out)) != LEVEL_10) begin
                bad++; $display("FAIL map_10 got=%0d want=%0d", $signed(sym_out), LEVEL_10);
            end
        end
        have_prev = 1;
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (sam_clk_en !== 1'b0 || sym_clk_en !== 1'b0 || sym_bits !== 2'b00 ||
            sym_out !== 18'd0 || frame_start !== 1'b0 || dut.u_lfsr.state_q !== 15'h7FFF) begin
            bad++;
            $display("FAIL %s got=%b%b/%b/%0d/%b/%h want=00/00/0/0/7fff", tag, sam_clk_en, sym_clk_en,
                     sym_bits, $signed(sym_out), frame_start, dut.u_lfsr.state_q);
        end
    endtask

    task automatic check_strobes(input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            total++;
            if (sam_clk_en !== ((c % CPS) == 0)) begin
                bad++; $display("FAIL sam_strobe cyc=%0d got=%b want=%b", c, sam_clk_en, (c % CPS) == 0);
            end
            total++;
            if (sym_clk_en !== ((c % (4 * CPS)) == 0)) begin
                bad++; $display("FAIL sym_strobe cyc=%0d got=%b want=%b", c, sym_clk_en, (c % (4 * CPS)) == 0);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_idle("reset_state");
    endtask

    task automatic test_strobes();
        do_reset();
        run = 1'b1;
        check_strobes(40);
    endtask

    task automatic test_first_symbols();
        do_reset();
        run_symbol(1'b1);
        total++;
        if (sym_bits !== 2'b00 || int'($signed(sym_out)) != -98304 || frame_start !== 1'b1) begin
            bad++; $display("FAIL first_symbol got=%b/%0d/%b want=00/-98304/1", sym_bits, $signed(sym_out), frame_start);
        end
        run_symbol(1'b1);
        total++;
        if (frame_start !== 1'b0) begin
            bad++; $display("FAIL second_frame_start got=%b want=0", frame_start);
        end
    endtask

    task automatic test_frame();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            run_symbol(1'b1);
            total++;
            if (frame_start !== ((k % 4) == 0)) begin
                bad++; $display("FAIL frame_mark sym=%0d got=%b want=%b", k, frame_start, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_run_gap();
        do_reset();
        repeat (5) run_symbol(1'b1);
        for (int k = 0; k < 3; k++) begin
            run_symbol(1'b0);
            total++;
            if (sym_out !== 18'd0 || int'(dut.u_lfsr.state_q) != m_lfsr) begin
                bad++; $display("FAIL gap_hold got=%0d/%h want=0/%h", $signed(sym_out), dut.u_lfsr.state_q, m_lfsr[14:0]);
            end
        end
        run_symbol(1'b1);
        total++;
        if (frame_start !== 1'b1) begin
            bad++; $display("FAIL restart_frame got=%b want=1", frame_start);
        end
        repeat (3) run_symbol(1'b1);
    endtask

    task automatic test_zero_reload();
        int nz;
        do_reset();
        repeat (3) run_symbol(1'b1);
        force dut.u_lfsr.state_q = 15'd0;
        #1;
        release dut.u_lfsr.state_q;
        m_lfsr = 0;
        run_symbol(1'b1);
        total++;
        if (dut.u_lfsr.state_q !== 15'h7FFF) begin
            bad++; $display("FAIL zero_reload got=%h want=7fff", dut.u_lfsr.state_q);
        end
        nz = 0;
        for (int k = 0; k < 10; k++) begin
            run_symbol(1'b1);
            if (sym_bits != 2'b00) nz++;
        end
        total++;
        if (nz == 0) begin
            bad++; $display("FAIL stuck_zero got=%0d nonzero want>0", nz);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 60; k++)
            run_symbol($urandom_range(0, 3) != 0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        run = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_strobes(16);
        run_symbol(1'b1);
        repeat (4) run_symbol(1'b1);
    endtask

    initial begin
        test_reset();
        test_strobes();
        test_first_symbols();
        test_frame();
        test_run_gap();
        test_zero_reload();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
